// File: rtl/multi_cycle_hazard_scoreboard.sv
// Per-register countdown scoreboard producing decode stall and bypass selects.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
module multi_cycle_hazard_scoreboard #(
  parameter int CORE          = 0,
  parameter int REG_BITS      = 5,
  parameter int BYPASS_STAGES = 3,
  parameter int MAX_LATENCY   = 7,
  parameter int LAT_BITS      = $clog2(MAX_LATENCY + 1),
  parameter int SEL_BITS      = $clog2(BYPASS_STAGES + 1),
  parameter int PERF_BITS     = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              issue_valid,
  input  logic [REG_BITS-1:0]               rs1,
  input  logic [REG_BITS-1:0]               rs2,
  input  logic                              rs1_read,
  input  logic                              rs2_read,
  input  logic [REG_BITS-1:0]               rd_decode,
  input  logic                              regWrite_decode,
  input  logic [LAT_BITS-1:0]               latency_decode,
  input  logic [BYPASS_STAGES*REG_BITS-1:0] rd_stage,
  input  logic [BYPASS_STAGES-1:0]          regWrite_stage,
  input  logic                              kill_execute,
  output logic                              stall_decode,
  output logic [SEL_BITS-1:0]               rs1_bypass,
  output logic [SEL_BITS-1:0]               rs2_bypass,
  output logic [PERF_BITS-1:0]              stall_cycles,
  output logic [PERF_BITS-1:0]              bypass_events
);

  localparam int NUM_REGS = 1 << REG_BITS;
  localparam logic [LAT_BITS-1:0] MAX_LAT = LAT_BITS'(MAX_LATENCY);

  logic [LAT_BITS-1:0] pending_r [NUM_REGS];
  logic [REG_BITS-1:0] last_rd_r;
  logic                last_valid_r;

  logic                rs1_busy;
  logic                rs2_busy;
  logic                issue_accept;
  logic                issue_write;
  logic [LAT_BITS-1:0] lat_sat;
  logic                unused_core;

  assign unused_core = ^CORE;

  // Lowest-index matching stage wins, so the search runs from the far end down.
  function automatic logic [SEL_BITS-1:0] bypass_sel(
    input logic [REG_BITS-1:0]               rs,
    input logic                              rs_en,
    input logic [BYPASS_STAGES*REG_BITS-1:0] rds,
    input logic [BYPASS_STAGES-1:0]          wes
  );
    logic [SEL_BITS-1:0] sel;
    sel = '0;
    if (rs_en && (rs != '0)) begin
      for (int k = BYPASS_STAGES - 1; k >= 0; k--) begin
        if (wes[k] && (rds[k*REG_BITS +: REG_BITS] == rs)) begin
          sel = SEL_BITS'(k + 1);
        end else begin
          sel = sel;
        end
      end
    end else begin
      sel = '0;
    end
    return sel;
  endfunction

  // Stall, acceptance and bypass selects from registered state and current inputs.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_read && (rs1 != '0)) begin
      rs1_busy = (pending_r[rs1] != '0);
    end else begin
      rs1_busy = 1'b0;
    end
    if (rs2_read && (rs2 != '0)) begin
      rs2_busy = (pending_r[rs2] != '0);
    end else begin
      rs2_busy = 1'b0;
    end
    stall_decode = issue_valid && (rs1_busy || rs2_busy);
    issue_accept = issue_valid && !stall_decode;
    issue_write  = issue_accept && regWrite_decode && (rd_decode != '0);
    if (latency_decode > MAX_LAT) begin
      lat_sat = MAX_LAT;
    end else begin
      lat_sat = latency_decode;
    end
    rs1_bypass = bypass_sel(rs1, rs1_read, rd_stage, regWrite_stage);
    rs2_bypass = bypass_sel(rs2, rs2_read, rd_stage, regWrite_stage);
  end

  // Scoreboard countdown: new issue beats kill, kill beats decrement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pending_r[r] <= '0;
      end
      last_rd_r    <= '0;
      last_valid_r <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue_write && (rd_decode == REG_BITS'(r))) begin
          pending_r[r] <= lat_sat;
        end else if (kill_execute && last_valid_r && (last_rd_r == REG_BITS'(r))) begin
          pending_r[r] <= '0;
        end else if (pending_r[r] != '0) begin
          pending_r[r] <= pending_r[r] - LAT_BITS'(1);
        end else begin
          pending_r[r] <= pending_r[r];
        end
      end
      last_rd_r    <= rd_decode;
      last_valid_r <= issue_write;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [PERF_BITS-1:0] stall_cnt_r;
  logic [PERF_BITS-1:0] bypass_cnt_r;

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_r  <= '0;
      bypass_cnt_r <= '0;
    end else begin
      if (issue_valid && stall_decode && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + PERF_BITS'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (issue_accept && ((rs1_bypass != '0) || (rs2_bypass != '0)) &&
          (bypass_cnt_r != '1)) begin
        bypass_cnt_r <= bypass_cnt_r + PERF_BITS'(1);
      end else begin
        bypass_cnt_r <= bypass_cnt_r;
      end
    end
  end

  assign stall_cycles  = stall_cnt_r;
  assign bypass_events = bypass_cnt_r;
`else
  assign stall_cycles  = '0;
  assign bypass_events = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_hazard_scoreboard.sv
// Directed and randomized bench for multi_cycle_hazard_scoreboard against a
// ready-time reference model (each register records the cycle it becomes available).
module tb_multi_cycle_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  rs1, rs2;
  logic        rs1_read, rs2_read;
  logic [4:0]  rd_decode;
  logic        regWrite_decode;
  logic [2:0]  latency_decode;
  logic [14:0] rd_stage;
  logic [2:0]  regWrite_stage;
  logic        kill_execute;
  logic        stall_decode;
  logic [1:0]  rs1_bypass, rs2_bypass;
  logic [31:0] stall_cycles, bypass_events;

  int errors = 0;
  int checks = 0;

  int ready_at [32];
  int cyc;
  bit m_last_valid;
  int m_last_rd;
  int m_stalls;
  int m_bypasses;

  always #5 clock = ~clock;

  multi_cycle_hazard_scoreboard dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2), .rs1_read(rs1_read), .rs2_read(rs2_read),
    .rd_decode(rd_decode), .regWrite_decode(regWrite_decode),
    .latency_decode(latency_decode), .rd_stage(rd_stage),
    .regWrite_stage(regWrite_stage), .kill_execute(kill_execute),
    .stall_decode(stall_decode), .rs1_bypass(rs1_bypass), .rs2_bypass(rs2_bypass),
    .stall_cycles(stall_cycles), .bypass_events(bypass_events)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_sel(input logic [4:0] rs, input logic rd_en);
    if (!rd_en || rs == 5'd0) return 0;
    for (int k = 0; k < 3; k++)
      if (regWrite_stage[k] && rd_stage[k*5 +: 5] == rs) return k + 1;
    return 0;
  endfunction

  function automatic bit busy(input logic [4:0] rs, input logic rd_en);
    return rd_en && rs != 5'd0 && ready_at[rs] > cyc;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    m_last_valid = 1'b0;
    m_last_rd = 0;
    m_stalls = 0;
    m_bypasses = 0;
  endtask

  task automatic idle();
    issue_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rs1_read = 1'b0; rs2_read = 1'b0;
    rd_decode = 5'd0; regWrite_decode = 1'b0; latency_decode = 3'd0;
    rd_stage = 15'd0; regWrite_stage = 3'd0; kill_execute = 1'b0;
  endtask

  task automatic perf_chk(input string tag);
`ifdef HAZARD_PERF_COUNTERS_EN
    chk({tag, "_stall_cnt"}, stall_cycles, m_stalls);
    chk({tag, "_byp_cnt"}, bypass_events, m_bypasses);
`else
    chk({tag, "_stall_cnt"}, stall_cycles, 32'd0);
    chk({tag, "_byp_cnt"}, bypass_events, 32'd0);
`endif
  endtask

  // One clock cycle: predict, check at the falling edge, advance the model.
  task automatic tick();
    bit es, acc, wr;
    int e1, e2, lat;
    es = issue_valid && (busy(rs1, rs1_read) || busy(rs2, rs2_read));
    e1 = exp_sel(rs1, rs1_read);
    e2 = exp_sel(rs2, rs2_read);
    @(negedge clock);
    chk("stall", 32'(stall_decode), 32'(es));
    chk("rs1_byp", 32'(rs1_bypass), e1);
    chk("rs2_byp", 32'(rs2_bypass), e2);
    perf_chk("cyc");
    if (issue_valid && es) m_stalls++;
    acc = issue_valid && !es;
    if (acc && (e1 != 0 || e2 != 0)) m_bypasses++;
    wr = acc && regWrite_decode && rd_decode != 5'd0;
    if (kill_execute && m_last_valid && !(wr && int'(rd_decode) == m_last_rd))
      if (ready_at[m_last_rd] > cyc + 1) ready_at[m_last_rd] = cyc + 1;
    if (wr) begin
      lat = int'(latency_decode);
      if (lat > 7) lat = 7;
      ready_at[rd_decode] = cyc + lat + 1;
    end
    m_last_valid = wr;
    m_last_rd = int'(rd_decode);
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic produce(input logic [4:0] rd, input logic [2:0] lat);
    idle();
    issue_valid = 1'b1; rd_decode = rd; regWrite_decode = 1'b1; latency_decode = lat;
  endtask

  task automatic consume(input logic [4:0] a, input logic [4:0] b);
    idle();
    issue_valid = 1'b1; rs1 = a; rs2 = b; rs1_read = 1'b1; rs2_read = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cyc = 0;
    model_reset();
    consume(5'd1, 5'd2);
    #12;
    chk("rst_stall", 32'(stall_decode), 32'd0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_byp_cnt", bypass_events, 32'd0);
    idle();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // ALU producer, consumer bypasses from execute.
    produce(5'd5, 3'd0); tick();
    consume(5'd5, 5'd0); rs2_read = 1'b0;
    rd_stage = {10'd0, 5'd5}; regWrite_stage = 3'b001;
    #2;
    chk("alu_stall", 32'(stall_decode), 32'd0);
    chk("alu_byp", 32'(rs1_bypass), 32'd1);
    tick();

    // Load producer, one bubble then memory bypass on both operands.
    produce(5'd6, 3'd1); tick();
    consume(5'd6, 5'd6); rd_decode = 5'd7; regWrite_decode = 1'b1;
    rd_stage = {10'd0, 5'd6}; regWrite_stage = 3'b001;
    #2;
    chk("load_stall", 32'(stall_decode), 32'd1);
    tick();
    rd_stage = {5'd0, 5'd6, 5'd0}; regWrite_stage = 3'b010;
    #2;
    chk("load_issue", 32'(stall_decode), 32'd0);
    chk("load_byp1", 32'(rs1_bypass), 32'd2);
    chk("load_byp2", 32'(rs2_bypass), 32'd2);
    tick();

    // Multiply producer with latency 3.
    produce(5'd8, 3'd3); tick();
    consume(5'd8, 5'd0); rs2_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("mul_stall", 32'(stall_decode), 32'd1);
      tick();
    end
    #2;
    chk("mul_issue", 32'(stall_decode), 32'd0);
`ifdef HAZARD_PERF_COUNTERS_EN
    chk("mul_stall_cnt", stall_cycles, 32'd4);
`else
    chk("mul_stall_cnt", stall_cycles, 32'd0);
`endif
    tick();

    // Kill clears the last producer.
    produce(5'd9, 3'd4); tick();
    idle(); kill_execute = 1'b1; tick();
    consume(5'd9, 5'd0);
    #2;
    chk("kill_nostall", 32'(stall_decode), 32'd0);
    tick();

    // Kill coinciding with a new issue to the same register: new issue wins.
    produce(5'd9, 3'd4); tick();
    produce(5'd9, 3'd2); kill_execute = 1'b1; tick();
    consume(5'd9, 5'd0);
    #2; chk("reissue_stall_a", 32'(stall_decode), 32'd1); tick();
    #2; chk("reissue_stall_b", 32'(stall_decode), 32'd1); tick();
    #2; chk("reissue_issue", 32'(stall_decode), 32'd0); tick();

    // x0 is never tracked or bypassed.
    produce(5'd0, 3'd5); tick();
    consume(5'd0, 5'd0); rd_stage = 15'd0; regWrite_stage = 3'b111;
    #2;
    chk("x0_stall", 32'(stall_decode), 32'd0);
    chk("x0_byp1", 32'(rs1_bypass), 32'd0);
    chk("x0_byp2", 32'(rs2_bypass), 32'd0);
    tick();

    // Reset asserted in the middle of a stall.
    produce(5'd10, 3'd3); tick();
    consume(5'd10, 5'd0); rs2_read = 1'b0;
    tick();
    #2;
    chk("pre_rst_stall", 32'(stall_decode), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall_decode), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int r = 1; r < 32; r++) begin
      consume(5'(r), 5'(r));
      #1;
      chk("rst_pending", 32'(stall_decode), 32'd0);
    end
    chk("rst_stall_cnt2", stall_cycles, 32'd0);
    chk("rst_byp_cnt2", bypass_events, 32'd0);
    idle();
    @(posedge clock);
    #1;

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 800; n++) begin
      idle();
      issue_valid     = ($urandom_range(0, 3) != 0);
      rs1             = 5'($urandom_range(0, 7));
      rs2             = 5'($urandom_range(0, 7));
      rs1_read        = 1'($urandom_range(0, 1));
      rs2_read        = 1'($urandom_range(0, 1));
      rd_decode       = 5'($urandom_range(0, 7));
      regWrite_decode = 1'($urandom_range(0, 1));
      latency_decode  = 3'($urandom_range(0, 7));
      rd_stage        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      regWrite_stage  = 3'($urandom_range(0, 7));
      kill_execute    = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
